phase_matrix_serializer: RTL and testbench

//  Transmit end of the serial phase link feeding control_to_neuron. Captures one 5x3 matrix
//  of 4-bit oscillator phases as a flat 60-bit word, then shifts it out one bit per clock,
//  MSB of element (0,0) first. The receiver rebuilds the same flat phi vector from the stream.

---
 rtl/onn_link_pkg.sv | 25 ++
 rtl/phase_shift_reg.sv | 57 +++++
 rtl/phase_matrix_serializer.sv | 140 ++++++++++++++
 tb/tb_phase_matrix_serializer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onn_link_pkg.sv
// -----------------------------------------------------------------------------
// onn_link_pkg
// Shared definitions for both ends of the serial phase link (serializer and
// control_to_neuron receiver): matrix geometry, frame payload size, counter
// width and the link FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package onn_link_pkg;

  localparam int ROWS = 5;                 // matrix rows
  localparam int COLS = 3;                 // matrix columns
  localparam int W    = 4;                 // bits per phase element
  localparam int N    = ROWS * COLS * W;   // frame payload bits
  localparam int CW   = $clog2(N + 1);     // bit counter width

  // Count value carried by the last payload bit of a frame.
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10
  } link_state_e;

endpackage

// File: rtl/phase_shift_reg.sv
// -----------------------------------------------------------------------------
// phase_shift_reg
// N-bit load / shift-left register with a running even-parity accumulator.
// The register is declared [0:N-1] so index 0 is the MSB and is the bit on the
// wire; a left shift moves index 1 into index 0. The accumulator XORs in every
// bit as it leaves, so once all N bits have been shifted out it holds the
// parity of the whole payload.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : capture load_data, clear the parity accumulator
//   shift       : shift left by one, fold the departing bit into the parity
//   sel_parity  : present the accumulated parity instead of the data MSB
//   load_data   : [0:N_BITS-1] word to capture
//   ser_bit     : current serial bit (data MSB or parity)
// -----------------------------------------------------------------------------
module phase_shift_reg
  import onn_link_pkg::*;
#(
  parameter int N_BITS = N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic              sel_parity,
  input  logic [0:N_BITS-1] load_data,
  output logic              ser_bit
);

  logic [0:N_BITS-1] shreg_q, shreg_d;
  logic              parity_q, parity_d;

  always_comb begin
    shreg_d  = shreg_q;
    parity_d = parity_q;
    if (load) begin
      shreg_d  = load_data;
      parity_d = 1'b0;
    end else if (shift) begin
      shreg_d  = {shreg_q[1:N_BITS-1], 1'b0};
      parity_d = parity_q ^ shreg_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
    end
  end

  assign ser_bit = sel_parity ? parity_q : shreg_q[0];

endmodule

// File: rtl/phase_matrix_serializer.sv
// -----------------------------------------------------------------------------
// phase_matrix_serializer
// Transmit end of the serial phase link. Captures one 5x3 matrix of 4-bit
// phases as a flat [0:N-1] word and shifts it out one bit per enabled clock,
// phi_in[0] first (row-major elements, each MSB first).
//
// Optional feature macro: SER_PARITY_EN
//   defined   : a PARITY state follows the payload and sends one even-parity
//               bit; frame_done moves onto that bit (frame length N+1).
//   undefined : frame length N, frame_done on payload bit N-1.
//
// Ports:
//   clk          : clock, all logic on the rising edge
//   rst          : synchronous active-high reset (aborts a frame, no done)
//   phi_in       : [0:N-1] flat phase matrix, element k at [k*W +: W], MSB first
//   load_valid   : phi_in valid, request to start a frame
//   load_ready   : serializer can accept a frame (IDLE only)
//   tx_en        : 1 = advance one bit this cycle, 0 = hold everything
//   bit_out      : serial data bit
//   bit_valid    : bit_out carries a frame bit this cycle
//   frame_start  : one-cycle pulse with the first bit of a frame
//   frame_done   : one-cycle pulse with the last bit of a frame
//   dbg_state    : current FSM state
//
// Load handshake: a frame is accepted on a rising edge where load_valid and
// load_ready are both 1; phi_in is sampled on that edge. load_ready is 1 only
// in IDLE (and not while rst is asserted); load_valid outside that window is
// ignored, nothing is queued. The first bit appears in the following cycle.
// -----------------------------------------------------------------------------
module phase_matrix_serializer
  import onn_link_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [0:N-1]  phi_in,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic          tx_en,
  output logic          bit_out,
  output logic          bit_valid,
  output logic          frame_start,
  output logic          frame_done,
  output link_state_e   dbg_state
);

  link_state_e     state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  // High in the first cycle a bit is presented; low while that bit is held by
  // a stall. Keeps frame_start / frame_done from repeating during stalls.
  logic            new_bit_q, new_bit_d;

  logic            load_fire;
  logic            busy;
  logic            shift_en;
  logic            sel_parity;
  logic            ser_bit;

  always_comb begin
    load_ready = (state_q == IDLE) && !rst;
    load_fire  = load_valid && load_ready;
    busy       = (state_q != IDLE);
    shift_en   = (state_q == SHIFT) && tx_en;
    new_bit_d  = load_fire || (busy && tx_en);
    state_d    = state_q;
    count_d    = count_q;

    case (state_q)
      IDLE: begin
        if (load_fire) begin
          state_d = SHIFT;
          count_d = '0;
        end
      end
      SHIFT: begin
        if (tx_en) begin
          // The counter never wraps: the last bit forces the exit.
          if (count_q == LAST_CNT) begin
`ifdef SER_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
`endif
            count_d = '0;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      PARITY: begin
`ifdef SER_PARITY_EN
        if (tx_en) begin
          state_d = IDLE;
        end
`else
        // Not reachable without the parity bit; fall back to IDLE.
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      new_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      new_bit_q <= new_bit_d;
    end
  end

`ifdef SER_PARITY_EN
  assign sel_parity = (state_q == PARITY);
  assign frame_done = (state_q == PARITY) && new_bit_q;
`else
  assign sel_parity = 1'b0;
  assign frame_done = (state_q == SHIFT) && (count_q == LAST_CNT) && new_bit_q;
`endif

  assign frame_start = (state_q == SHIFT) && (count_q == '0) && new_bit_q;
  assign bit_valid   = busy;
  assign bit_out     = busy && ser_bit;
  assign dbg_state   = state_q;

  phase_shift_reg #(
    .N_BITS (N)
  ) u_shift_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load_fire),
    .shift      (shift_en),
    .sel_parity (sel_parity),
    .load_data  (phi_in),
    .ser_bit    (ser_bit)
  );

endmodule

// File: tb/tb_phase_matrix_serializer.sv
// -----------------------------------------------------------------------------
// tb_phase_matrix_serializer
// Directed bench for phase_matrix_serializer. Stimulus pushes the expected
// bit stream (bit, start, done) into exp_q and the frame word into frame_q;
// a negedge monitor pops and compares whenever bit_valid is high and rebuilds
// the received word the way the receiver does.
// -----------------------------------------------------------------------------
module tb_phase_matrix_serializer;
  import onn_link_pkg::*;

`ifdef SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = N + PAR;

  // ---------------- clock / reset / DUT ----------------
  logic          clk;
  logic          rst;
  logic [0:N-1]  phi_in;
  logic          load_valid;
  logic          load_ready;
  logic          tx_en;
  logic          bit_out;
  logic          bit_valid;
  logic          frame_start;
  logic          frame_done;
  link_state_e   dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  phase_matrix_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .phi_in      (phi_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .tx_en       (tx_en),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int           checks = 0;
  int           errors = 0;
  logic [2:0]   exp_q[$];      // {bit, frame_start, frame_done}
  logic [0:N-1] frame_q[$];
  int           start_cnt = 0;
  int           done_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_frame(input logic [0:N-1] v);
    for (int i = 0; i < N; i++)
      exp_q.push_back({v[i], (i == 0), (PAR == 0) && (i == N - 1)});
    if (PAR != 0) exp_q.push_back({^v, 1'b0, 1'b1});
    frame_q.push_back(v);
  endtask

  task automatic load_frame(input logic [0:N-1] v, input string name);
    int w;
    w          = 0;
    phi_in     = v;
    load_valid = 1'b1;
    while (!load_ready && w < 200) begin
      tick();
      w++;
    end
    check({name, "_load_ready_wait"}, 64'(w < 200), 64'(1));
    push_frame(v);
    tick();
    load_valid = 1'b0;
  endtask

  // Runs from the cycle after the load edge until bit_valid drops.
  task automatic measure_frame(input bit toggle, input string name,
                               output int valid_cyc, output int done_at);
    int s0;
    int d0;
    s0        = start_cnt;
    d0        = done_cnt;
    valid_cyc = 0;
    done_at   = 0;
    for (int i = 1; i <= 400; i++) begin
      tx_en = toggle ? ((i % 2) == 0) : 1'b1;
      @(negedge clk);
      if (i == 1) check({name, "_start_latency"}, 64'(frame_start), 64'(1));
      if (!bit_valid) break;
      valid_cyc++;
      if (frame_done) done_at = i;
      @(posedge clk);
      #1;
    end
    tx_en = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_start_pulses"}, 64'(start_cnt - s0), 64'(1));
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
  endtask

  // ---------------- monitor ----------------
  logic         held = 1'b0;
  int           rx_cnt = 0;
  logic [0:N-1] rx;
  logic [2:0]   e, exp3, got3;

  always @(negedge clk) begin
    if (rst) begin
      held   = 1'b0;
      rx_cnt = 0;
    end else begin
      if (frame_start) start_cnt++;
      if (frame_done)  done_cnt++;
      if (bit_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 64'(exp_q.size()), 64'(1));
        end else begin
          e    = exp_q[0];
          exp3 = {e[2], e[1] & ~held, e[0] & ~held};
          got3 = {bit_out, frame_start, frame_done};
          check("stream_bit_start_done", 64'(got3), 64'(exp3));
          if (!held) begin
            if (rx_cnt < N) rx[rx_cnt] = bit_out;
            rx_cnt++;
            if (e[0]) begin
              if (frame_q.size() == 0)
                check("loopback_frame_missing", 64'(frame_q.size()), 64'(1));
              else
                check("loopback_phi", 64'(rx), 64'(frame_q.pop_front()));
              rx_cnt = 0;
            end
          end
          if (tx_en) begin
            void'(exp_q.pop_front());
            held = 1'b0;
          end else begin
            held = 1'b1;
          end
        end
      end else begin
        held = 1'b0;
        check("idle_outputs", 64'({bit_out, frame_start, frame_done}), 64'(0));
      end
    end
  end

  // ---------------- stimulus ----------------
  int           vc, da;
  logic         valid_log [1:140];
  int           v1, v2;
  logic [0:N-1] va, vb;

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    tx_en      = 1'b1;
    phi_in     = '0;
    tick(); tick();
    @(negedge clk);
    check("por_outputs", 64'({bit_out, bit_valid, frame_start, frame_done}), 64'(0));
    check("por_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("por_load_ready", 64'(load_ready), 64'(1));
    tick();

    // 1111 0000 0000 repeated five times
    load_frame(60'hF00F00F00F00F00, "t2");
    measure_frame(1'b0, "t2", vc, da);
    check("t2_valid_cycles", 64'(vc), 64'(FL));
    check("t2_done_cycle", 64'(da), 64'(FL));

    // random-looking matrix, checked by the loopback word compare
    load_frame(60'h5A3C96E1B742D8F, "t3");
    measure_frame(1'b0, "t3", vc, da);
    check("t3_valid_cycles", 64'(vc), 64'(FL));

    // tx_en toggling: every bit held two cycles, last bit is the single 1
    load_frame(60'h1, "t4");
    measure_frame(1'b1, "t4", vc, da);
    check("t4_valid_cycles", 64'(vc), 64'(2 * FL));
    check("t4_done_cycle", 64'(da), 64'(2 * FL - 1));

    // reset held three cycles in the middle of a frame
    load_frame(60'hABCDEF012345678, "t1");
    repeat (20) tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    frame_q.delete();
    tick(); tick();
    @(negedge clk);
    check("rst_outputs", 64'({bit_out, bit_valid, frame_start, frame_done}), 64'(0));
    check("rst_load_ready", 64'(load_ready), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_load_ready", 64'(load_ready), 64'(1));
    tick();

    // load_valid held high: one idle cycle between frames, second frame
    // takes the phi_in present in that idle cycle
    va = 60'h123456789ABCDEF;
    vb = 60'hFEDCBA987654321;
    phi_in     = va;
    load_valid = 1'b1;
    push_frame(va);
    push_frame(vb);
    tick();
    for (int i = 1; i <= 2 * FL + 4; i++) begin
      if (i == 5) phi_in = vb;
      if (i == FL + 3) load_valid = 1'b0;
      @(negedge clk);
      valid_log[i] = bit_valid;
      if (i == 5) check("t5_ready_mid_frame", 64'(load_ready), 64'(0));
      @(posedge clk); #1;
    end
    v1 = 0;
    v2 = 0;
    for (int i = 1; i <= FL; i++) v1 += int'(valid_log[i]);
    for (int i = FL + 2; i <= 2 * FL + 1; i++) v2 += int'(valid_log[i]);
    check("t5_first_len", 64'(v1), 64'(FL));
    check("t5_gap", 64'(valid_log[FL + 1]), 64'(0));
    check("t5_second_len", 64'(v2), 64'(FL));
    check("t5_tail_idle", 64'(valid_log[2 * FL + 2]), 64'(0));

    // seven ones (parity 1) and six ones (parity 0)
    load_frame(60'h7F, "t6a");
    measure_frame(1'b0, "t6a", vc, da);
    check("t6a_done_cycle", 64'(da), 64'(FL));
    load_frame(60'h3F, "t6b");
    measure_frame(1'b0, "t6b", vc, da);
    check("t6b_valid_cycles", 64'(vc), 64'(FL));

    repeat (5) tick();
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    check("frame_q_drained", 64'(frame_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
